// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a 1-cycle-latency RAM.
// A 2-entry output buffer hides the read latency.
module ram_fifo_ctrl #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [D_WIDTH-1:0] in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [D_WIDTH-1:0] out_data,
  input  logic               out_ready,
  output logic [A_WIDTH+1:0] level,
  output logic               write_en,
  output logic [A_WIDTH-1:0] write_addr,
  output logic [D_WIDTH-1:0] write_data,
  output logic               read_en,
  output logic [A_WIDTH-1:0] read_addr,
  input  logic [D_WIDTH-1:0] read_data,
  input  logic               read_valid
);

  logic [A_WIDTH:0]   wp;
  logic [A_WIDTH:0]   rp;
  logic [A_WIDTH:0]   ram_cnt;
  logic               ram_full;
  logic               ram_empty;
  logic [1:0]         buf_cnt;
  logic               infl;
  logic [D_WIDTH-1:0] obuf [2];
  logic               push;
  logic               pop;
  logic               capture;
  logic [2:0]         occ;

  assign ram_cnt   = wp - rp;
  assign ram_full  = (ram_cnt == {1'b1, {A_WIDTH{1'b0}}});
  assign ram_empty = (wp == rp);

  // rst gating keeps the RAM strobes quiet while reset is held
  assign in_ready = !rst || (!ram_full && !flush);
  assign push     = rst && in_valid && !ram_full && !flush;
  assign pop      = out_valid && out_ready;
  assign capture  = read_valid && infl && !flush;

  assign write_en   = push;
  assign write_addr = wp[A_WIDTH-1:0];
  assign write_data = in_data;

  assign occ = {1'b0, buf_cnt} + {2'b00, infl} - {2'b00, pop};

  assign read_en   = rst && !ram_empty && !flush && (occ < 3'd2);
  assign read_addr = rp[A_WIDTH-1:0];

  assign out_valid = (buf_cnt != 2'd0);
  assign out_data  = obuf[0];

  assign level = {1'b0, ram_cnt}
               + {{(A_WIDTH+1){1'b0}}, infl}
               + {{A_WIDTH{1'b0}}, buf_cnt};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp      <= '0;
      rp      <= '0;
      buf_cnt <= 2'd0;
      infl    <= 1'b0;
      obuf[0] <= '0;
      obuf[1] <= '0;
    end else if (flush) begin
      wp      <= '0;
      rp      <= '0;
      buf_cnt <= 2'd0;
      infl    <= 1'b0;
    end else begin
      if (push)
        wp <= wp + 1'b1;
      if (read_en)
        rp <= rp + 1'b1;
      infl <= read_en || (infl && !read_valid);
      // capture+pop keeps buf_cnt, shifting so order holds
      case ({capture, pop})
        2'b11: begin
          if (buf_cnt == 2'd2) begin
            obuf[0] <= obuf[1];
            obuf[1] <= read_data;
          end else begin
            obuf[0] <= read_data;
          end
        end
        2'b10: begin
          if (buf_cnt == 2'd0)
            obuf[0] <= read_data;
          else
            obuf[1] <= read_data;
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          obuf[0] <= obuf[1];
          buf_cnt <= buf_cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
